// File: rtl/mod_147_3_7_link_monitor_pkg.sv
// Clause 147 link-monitor shared definitions: state encodings, default
// qualification/hold cycle counts and counter width.
package pkg_147_link;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        LINK_QUAL = 2'd1,
        LINK_UP   = 2'd2,
        LINK_HOLD = 2'd3
    } lm_state_t;

    // 50 ms at 25 MHz
    localparam int unsigned LINK_QUAL_CYCLES_DEF = 1250000;
    localparam int unsigned LINK_HOLD_CYCLES_DEF = 1250000;
    localparam int unsigned CNT_W_DEF            = 21;

    function automatic logic link_is_ok(lm_state_t s);
        return (s == LINK_UP) || (s == LINK_HOLD);
    endfunction

endpackage

// File: rtl/mod_147_3_7_link_monitor_if.sv
// Control and status bundle of the Clause 147 link monitor.
interface mod_147_3_7_link_monitor_if;
    import pkg_147_link::*;

    logic      link_control;
    logic      pma_reset;
    logic      signal_ok;
    logic      link_status;
    logic      link_hold_timer_done;
    logic      link_hold_timer_not_done;
    lm_state_t lm_state;

    modport master (
        output link_control, pma_reset, signal_ok,
        input  link_status, link_hold_timer_done, link_hold_timer_not_done, lm_state
    );

    modport slave (
        input  link_control, pma_reset, signal_ok,
        output link_status, link_hold_timer_done, link_hold_timer_not_done, lm_state
    );

endinterface

// File: rtl/mod_147_3_7_2_link_hold_counter.sv
// Shared qualification/hold down-counter: load N-1 on start, expire N cycles
// later, saturate at zero when idle.
module mod_147_3_7_2_link_hold_counter #(
    parameter int unsigned CNT_W = 21
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire,
    output logic             done,
    output logic             not_done
);

    logic [CNT_W-1:0] count;
    logic             running;

    // Clear wins over start and over a coincident expiry, so an aborted
    // timer never produces a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                count   <= '0;
                running <= 1'b0;
            end else if (start) begin
                count   <= load_value;
                running <= 1'b1;
            end else if (running) begin
                if (count == '0) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    assign expire   = running && (count == '0);
    assign not_done = running;

endmodule

// File: rtl/mod_147_3_7_link_monitor.sv
// Clause 147 link monitor: qualifies signal_ok before declaring link up and
// tolerates short signal loss before declaring link down.
module mod_147_3_7_link_monitor
    import pkg_147_link::*;
#(
    parameter int unsigned LINK_QUAL_CYCLES = LINK_QUAL_CYCLES_DEF,
    parameter int unsigned LINK_HOLD_CYCLES = LINK_HOLD_CYCLES_DEF,
    parameter int unsigned CNT_W            = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mod_147_3_7_link_monitor_if.slave    lm
);

    localparam logic [CNT_W-1:0] QUAL_LOAD = CNT_W'(LINK_QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LINK_HOLD_CYCLES - 1);

    lm_state_t        state;
    lm_state_t        next_state;
    logic             force_down;
    logic             timer_start;
    logic             timer_clear;
    logic             timer_expire;
    logic             status_d;
    logic [CNT_W-1:0] load_value;

    assign force_down = !lm.link_control || lm.pma_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= LINK_DOWN;
            lm.link_status <= 1'b0;
        end else begin
            state          <= next_state;
            lm.link_status <= status_d;
        end
    end

    // A signal_ok change takes priority over a coincident timer expiry.
    always_comb begin
        next_state = LINK_DOWN;
        if (!force_down) begin
            case (state)
                LINK_DOWN: next_state = lm.signal_ok ? LINK_QUAL : LINK_DOWN;
                LINK_QUAL: begin
                    if (!lm.signal_ok)     next_state = LINK_DOWN;
                    else if (timer_expire) next_state = LINK_UP;
                    else                   next_state = LINK_QUAL;
                end
                LINK_UP:   next_state = lm.signal_ok ? LINK_UP : LINK_HOLD;
                LINK_HOLD: begin
                    if (lm.signal_ok)      next_state = LINK_UP;
                    else if (timer_expire) next_state = LINK_DOWN;
                    else                   next_state = LINK_HOLD;
                end
                default:   next_state = LINK_DOWN;
            endcase
        end
    end

    always_comb begin
        timer_start = 1'b0;
        timer_clear = force_down;
        load_value  = (state == LINK_UP) ? HOLD_LOAD : QUAL_LOAD;
        status_d    = link_is_ok(next_state);
        if (!force_down) begin
            timer_start = ((state == LINK_DOWN) &&  lm.signal_ok) ||
                          ((state == LINK_UP)   && !lm.signal_ok);
            timer_clear = ((state == LINK_QUAL) && !lm.signal_ok) ||
                          ((state == LINK_HOLD) &&  lm.signal_ok);
        end
    end

    mod_147_3_7_2_link_hold_counter #(
        .CNT_W (CNT_W)
    ) u_link_hold_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (timer_start),
        .clear      (timer_clear),
        .load_value (load_value),
        .expire     (timer_expire),
        .done       (lm.link_hold_timer_done),
        .not_done   (lm.link_hold_timer_not_done)
    );

    assign lm.lm_state = state;

endmodule

// File: tb/tb_mod_147_3_7_link_monitor.sv
// Self-checking bench for the Clause 147 link monitor: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_mod_147_3_7_link_monitor;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mod_147_3_7_link_monitor_if lm();

    mod_147_3_7_link_monitor #(
        .LINK_QUAL_CYCLES (N),
        .LINK_HOLD_CYCLES (N),
        .CNT_W            (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lm      (lm)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: st 0=down 1=qual 2=up 3=hold; el counts cycles since the timer
    // start edge, expiry is the cycle where el reaches N.
    typedef struct packed {
        int st;
        int el;
        bit run;
        bit dn;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_step(mdl_t c, bit lc, bit pr, bit ok);
        mdl_t n = c;
        bit expired = c.run && (c.el == N);
        bit stop = 1'b0, start = 1'b0, fin = 1'b0;
        n.dn = 1'b0;
        if (!lc || pr) begin
            n.st = 0; stop = 1'b1;
        end else begin
            case (c.st)
                0: if (ok) begin n.st = 1; start = 1'b1; end
                1: if (!ok) begin n.st = 0; stop = 1'b1; end
                   else if (expired) begin n.st = 2; fin = 1'b1; end
                2: if (!ok) begin n.st = 3; start = 1'b1; end
                default: if (ok) begin n.st = 2; stop = 1'b1; end
                         else if (expired) begin n.st = 0; fin = 1'b1; end
            endcase
        end
        if (stop) begin n.run = 1'b0; n.el = 0; end
        else if (start) begin n.run = 1'b1; n.el = 1; end
        else if (fin) begin n.run = 1'b0; n.el = 0; n.dn = 1'b1; end
        else if (c.run) n.el = c.el + 1;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_step(m, lm.link_control, lm.pma_reset, lm.signal_ok);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_lm_state", int'(lm.lm_state), m.st);
            chk("model_link_status", int'(lm.link_status), int'(m.st >= 2));
            chk("model_not_done", int'(lm.link_hold_timer_not_done), int'(m.run));
            chk("model_done", int'(lm.link_hold_timer_done), int'(m.dn));
        end
    end

    task automatic step(input bit lc, input bit pr, input bit ok);
        lm.link_control = lc;
        lm.pma_reset    = pr;
        lm.signal_ok    = ok;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input int st, input int ls,
                              input int nd, input int dn);
        chk({name, "_state"}, int'(lm.lm_state), st);
        chk({name, "_status"}, int'(lm.link_status), ls);
        chk({name, "_not_done"}, int'(lm.link_hold_timer_not_done), nd);
        chk({name, "_done"}, int'(lm.link_hold_timer_done), dn);
    endtask

    task automatic bring_up();
        for (int i = 0; i < N + 1; i++) step(1'b1, 1'b0, 1'b1);
        chk("bring_up_state", int'(lm.lm_state), 2);
    endtask

    task automatic async_reset_pulse(input bit literal);
        #2 reset_n = 1'b0;
        #1;
        if (literal) expect_out("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int run_left;
        bit ok_cur;
        reset_n         = 1'b0;
        lm.link_control = 1'b0;
        lm.pma_reset    = 1'b0;
        lm.signal_ok    = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Qualification: rises on the 9th edge counting the sampling edge
        step(1'b1, 1'b0, 1'b1);
        expect_out("qual_entry", 1, 0, 1, 0);
        for (int i = 2; i <= N; i++) step(1'b1, 1'b0, 1'b1);
        expect_out("qual_expiry_cycle", 1, 0, 1, 0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("qual_up", 2, 1, 0, 1);
        step(1'b1, 1'b0, 1'b1);
        expect_out("qual_done_once", 2, 1, 0, 0);

        // Short loss: HOLD then back to UP
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        expect_out("short_loss", 3, 1, 1, 0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("short_restore", 2, 1, 0, 0);

        // Restore in the exact expiry cycle of HOLD
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
        expect_out("hold_expiry_cycle", 3, 1, 1, 0);
        step(1'b1, 1'b0, 1'b1);
        expect_out("restore_at_expiry", 2, 1, 0, 0);

        // Long loss: down after N cycles in HOLD
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_out("long_loss_down", 0, 0, 0, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_out("long_loss_after", 0, 0, 0, 0);

        // Drop during qualification
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        expect_out("qual_abort", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);

        // pma_reset mid-HOLD
        bring_up();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        expect_out("pma_reset", 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);

        // link_control low forces down from UP
        bring_up();
        step(1'b0, 1'b0, 1'b1);
        expect_out("link_control_off", 0, 0, 0, 0);

        // Asynchronous reset mid-HOLD
        step(1'b1, 1'b0, 1'b0);
        bring_up();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        async_reset_pulse(1'b1);

        // Randomized traffic, run lengths clustered around the timer length
        ok_cur   = 1'b0;
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                ok_cur   = ~ok_cur;
                run_left = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12))
                                                       : int'($urandom_range(N - 1, N + 1));
            end
            run_left--;
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 59) == 0), ok_cur);
            if ($urandom_range(0, 299) == 0) async_reset_pulse(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_147_3_7_link_monitor.md
MOD_147_3_7_LINK_MONITOR -- requirements
Module: mod_147_3_7_link_monitor

Interface
REQ-001 Parameter LINK_QUAL_CYCLES, default 1250000, is the number of clk cycles signal_ok must be held to declare link up (50 ms at 25 MHz).
REQ-002 Parameter LINK_HOLD_CYCLES, default 1250000, is the number of clk cycles of signal loss tolerated before declaring link down (50 ms at 25 MHz).
REQ-003 Parameter CNT_W, default 21, is the counter width and SHALL satisfy 2^CNT_W > max(LINK_QUAL_CYCLES, LINK_HOLD_CYCLES).
REQ-004 clk  input  1  single block clock, rising-edge active.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 link_control  input  1  1 = link monitoring enabled; 0 = forced down.
REQ-007 pma_reset  input  1  synchronous PMA reset request; forces link down while high.
REQ-008 signal_ok  input  1  receive-path lock indication (descrambler locked), synchronous to clk.
REQ-009 link_status  output  1  1 = OK, 0 = FAIL.
REQ-010 link_hold_timer_done  output  1  pulses high one cycle when the running timer expires.
REQ-011 link_hold_timer_not_done  output  1  high while the timer is running.
REQ-012 lm_state  output  2  current state encoding, for observability.

Function
REQ-013 The block SHALL implement states LINK_DOWN=0, LINK_QUAL=1, LINK_UP=2, LINK_HOLD=3.
REQ-014 Force condition = (link_control==0) or (pma_reset==1); while it holds, the next state SHALL be LINK_DOWN and the timer SHALL be cleared, overriding every other transition.
REQ-015 LINK_DOWN: signal_ok=1 -> LINK_QUAL, timer loaded and started in the same edge.
REQ-016 LINK_QUAL: signal_ok=0 -> LINK_DOWN, timer cleared; timer expiry with signal_ok=1 -> LINK_UP.
REQ-017 LINK_UP: signal_ok=0 -> LINK_HOLD, timer loaded and started.
REQ-018 LINK_HOLD: signal_ok=1 -> LINK_UP, timer cleared; timer expiry with signal_ok=0 -> LINK_DOWN.
REQ-019 Simultaneous expiry and signal_ok change in the same cycle: the signal_ok transition SHALL take priority (QUAL -> DOWN, HOLD -> UP).
REQ-020 Timer: down-counter loaded with N-1 on start, decremented each cycle; expiry is the cycle the count equals 0 while running, i.e. exactly N cycles after the start edge.
REQ-021 link_hold_timer_not_done SHALL be high from the cycle after start until the expiry cycle inclusive; link_hold_timer_done SHALL be high only in the cycle after expiry, for one cycle.
REQ-022 link_status SHALL be registered: 1 in LINK_UP and LINK_HOLD, 0 in LINK_DOWN and LINK_QUAL.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W-bit with no wrap; it holds at 0 when idle.
REQ-024 Illegal/unreachable state values SHALL recover to LINK_DOWN on the next edge.

Reset
REQ-025 On reset_n low: state=LINK_DOWN, counter=0, link_status=0, link_hold_timer_done=0, link_hold_timer_not_done=0, lm_state=0, all asynchronously.
REQ-026 Reset assertion mid-qualification or mid-hold SHALL abort the timer; after deassertion the block restarts from LINK_DOWN.

Structure
REQ-027 State encodings and default cycle counts SHALL live in shared package pkg_147_link, alongside the other Clause 147 constants.
REQ-028 The timer SHALL be a sub-module mod_147_3_7_2_link_hold_counter (inputs start, clear, load value; outputs done, not_done) instantiated once and shared by QUAL and HOLD.
REQ-029 The state machine and output registers SHALL reside in mod_147_3_7_link_monitor; the block SHALL be synthesizable, with no simulation-only delay constructs.

Verification (LINK_QUAL_CYCLES=LINK_HOLD_CYCLES=8 for the bench)
REQ-030 Reset then link_control=1, signal_ok=1 held -> LINK_QUAL next edge; link_status rises exactly 9 edges after signal_ok sampled; done pulses once.
REQ-031 In LINK_QUAL drop signal_ok after 5 cycles -> LINK_DOWN next edge; link_status stays 0; no done pulse.
REQ-032 From LINK_UP drop signal_ok for 3 cycles then restore -> LINK_HOLD then LINK_UP; link_status stays 1 throughout.
REQ-033 From LINK_UP drop signal_ok for 10 cycles -> LINK_DOWN after 8 cycles in HOLD; link_status falls on that edge.
REQ-034 signal_ok restored in the exact expiry cycle of HOLD -> LINK_UP, not LINK_DOWN.
REQ-035 pma_reset pulse, or reset_n low, mid-LINK_HOLD -> LINK_DOWN, counter 0, not_done 0 immediately (reset_n asynchronously).
